// File: rtl/single_port_ram_be.sv
// single_port_ram_be: single-port scratchpad RAM with byte-lane write enables,
// a registered read path with a read-valid strobe, an out-of-range address flag
// and a hardware init sequencer that fills every word with InitVal after reset
// or on a clr request.
//
// Optional build macro: SP_RAM_OUT_REG_EN adds an output register after the
// array read (read latency 2, q_valid_o/addr_err_o delayed to match).
//
// Ports:
//   clk_i       clock, all logic on the rising edge
//   rst_ni      asynchronous active-low reset
//   clr_i       synchronous request to re-run the init sequence
//   en_i        access request, sampled only while ready_o=1
//   we_i        1 = write, 0 = read
//   be_i        byte-lane write enables, be_i[i] covers data_i[8i+7:8i]
//   addr_i      word address
//   data_i      write data
//   ready_o     1 = accepting requests, 0 during init
//   q_o         read data
//   q_valid_o   one-cycle strobe marking new read data on q_o
//   addr_err_o  one-cycle strobe for an access with addr_i >= Depth
module single_port_ram_be #(
    parameter int unsigned          AddrWidth = 6,
    parameter int unsigned          DataWidth = 32,
    parameter int unsigned          Depth     = 64,
    parameter logic [DataWidth-1:0] InitVal   = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clr_i,
    input  logic                   en_i,
    input  logic                   we_i,
    input  logic [DataWidth/8-1:0] be_i,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic [DataWidth-1:0]   data_i,
    output logic                   ready_o,
    output logic [DataWidth-1:0]   q_o,
    output logic                   q_valid_o,
    output logic                   addr_err_o
);

    localparam int unsigned NumLanes = DataWidth / 8;
    localparam int unsigned IdxWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(Depth - 1);
    // Depth widened by one bit so Depth == 2**AddrWidth still compares correctly.
    localparam logic [AddrWidth:0] DepthExt = (AddrWidth + 1)'(Depth);

    if ((DataWidth % 8) != 0 || DataWidth == 0) begin : gen_dw_err
        $error("single_port_ram_be: DataWidth must be a non-zero multiple of 8");
    end
    if (Depth < 2 || longint'(Depth) > (64'd1 << AddrWidth)) begin : gen_depth_err
        $error("single_port_ram_be: Depth must be >= 2 and <= 2**AddrWidth");
    end

    typedef enum logic [0:0] {StInit, StReady} state_e;

    state_e               state_q;
    logic [IdxWidth-1:0]  ptr_q;
    logic                 ready_q;
    logic [DataWidth-1:0] mem_q [Depth];

    logic                 acc;
    logic                 in_range;
    logic                 rd_hit;
    logic [IdxWidth-1:0]  idx;
    logic [DataWidth-1:0] rd_word;

    logic [DataWidth-1:0] q1_q;
    logic                 q_valid1_q;
    logic                 addr_err1_q;

    always_comb begin
        // clr wins over a request in the same cycle.
        acc      = (state_q == StReady) && en_i && !clr_i;
        in_range = {1'b0, addr_i} < DepthExt;
        rd_hit   = acc && !we_i;
        idx      = addr_i[IdxWidth-1:0];
        rd_word  = mem_q[idx];
    end

    // Init sequencer: one word per cycle, READY after the last word is written.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StInit;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else if (clr_i) begin
            state_q <= StInit;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                StInit: begin
                    if (ptr_q == LastIdx) begin
                        state_q <= StReady;
                        ptr_q   <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                StReady: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= StInit;
                    ptr_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Array has no reset; the init sequence overwrites every word.
    always_ff @(posedge clk_i) begin
        if (state_q == StInit) begin
            mem_q[ptr_q] <= InitVal;
        end else if (acc && we_i && in_range) begin
            for (int unsigned i = 0; i < NumLanes; i++) begin
                if (be_i[i]) begin
                    mem_q[idx][8*i +: 8] <= data_i[8*i +: 8];
                end
            end
        end
    end

    // First read stage; q holds between reads, out-of-range reads return 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q1_q        <= '0;
            q_valid1_q  <= 1'b0;
            addr_err1_q <= 1'b0;
        end else begin
            q_valid1_q  <= rd_hit;
            addr_err1_q <= acc && !in_range;
            if (rd_hit) begin
                q1_q <= in_range ? rd_word : '0;
            end
        end
    end

`ifdef SP_RAM_OUT_REG_EN
    logic [DataWidth-1:0] q2_q;
    logic                 q_valid2_q;
    logic                 addr_err2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q2_q        <= '0;
            q_valid2_q  <= 1'b0;
            addr_err2_q <= 1'b0;
        end else if (clr_i) begin
            q2_q        <= '0;
            q_valid2_q  <= 1'b0;
            addr_err2_q <= 1'b0;
        end else begin
            q_valid2_q  <= q_valid1_q;
            addr_err2_q <= addr_err1_q;
            if (q_valid1_q) begin
                q2_q <= q1_q;
            end
        end
    end

    assign q_o        = q2_q;
    assign q_valid_o  = q_valid2_q;
    assign addr_err_o = addr_err2_q;
`else
    assign q_o        = q1_q;
    assign q_valid_o  = q_valid1_q;
    assign addr_err_o = addr_err1_q;
`endif

    assign ready_o = ready_q;

endmodule

// File: tb/tb_single_port_ram_be.sv
// Directed self-checking bench for single_port_ram_be (AddrWidth=7, Depth=64
// so out-of-range addresses are reachable). Works with or without
// SP_RAM_OUT_REG_EN.
module tb_single_port_ram_be;

`ifdef SP_RAM_OUT_REG_EN
    localparam int Lat = 2;
`else
    localparam int Lat = 1;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clr_i = 1'b0;
    logic        en_i = 1'b0;
    logic        we_i = 1'b0;
    logic [3:0]  be_i = 4'h0;
    logic [6:0]  addr_i = '0;
    logic [31:0] data_i = '0;
    logic        ready_o;
    logic [31:0] q_o;
    logic        q_valid_o;
    logic        addr_err_o;

    int n_checks = 0;
    int n_errors = 0;
    int n_cyc;

    single_port_ram_be #(
        .AddrWidth(7),
        .DataWidth(32),
        .Depth    (64),
        .InitVal  (32'h0)
    ) u_dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (clr_i),
        .en_i      (en_i),
        .we_i      (we_i),
        .be_i      (be_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .ready_o   (ready_o),
        .q_o       (q_o),
        .q_valid_o (q_valid_o),
        .addr_err_o(addr_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Counts edges until ready_o rises, bounded.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready_o && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic do_read(input logic [6:0] a, input logic [31:0] exp_q, input logic exp_err);
        en_i = 1'b1; we_i = 1'b0; addr_i = a;
        tick();
        en_i = 1'b0;
`ifdef SP_RAM_OUT_REG_EN
        check("rd_early_valid", 32'(q_valid_o), 32'd0);
        tick();
`endif
        check("rd_valid", 32'(q_valid_o), 32'd1);
        check("rd_data", q_o, exp_q);
        check("rd_err", 32'(addr_err_o), 32'(exp_err));
        tick();
        check("rd_valid_drop", 32'(q_valid_o), 32'd0);
        check("rd_hold", q_o, exp_q);
    endtask

    task automatic do_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] b,
                            input logic exp_err);
        en_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d; be_i = b;
        tick();
        en_i = 1'b0; we_i = 1'b0;
`ifdef SP_RAM_OUT_REG_EN
        tick();
`endif
        check("wr_no_valid", 32'(q_valid_o), 32'd0);
        check("wr_err", 32'(addr_err_o), 32'(exp_err));
        tick();
        check("wr_err_drop", 32'(addr_err_o), 32'd0);
    endtask

    initial begin
        // Reset state.
        tick();
        tick();
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_q", q_o, 32'd0);
        check("rst_valid", 32'(q_valid_o), 32'd0);
        check("rst_err", 32'(addr_err_o), 32'd0);
        rst_ni = 1'b1;
        wait_ready(n_cyc);
        check("init_cycles", 32'(n_cyc), 32'd64);

        // Every word reads back as InitVal.
        for (int a = 0; a < 64; a++) begin
            do_read(7'(a), 32'h0, 1'b0);
        end

        // Byte-lane merge.
        do_write(7'd5, 32'hDEADBEEF, 4'b1111, 1'b0);
        do_write(7'd5, 32'h11223344, 4'b0101, 1'b0);
        do_read(7'd5, 32'hDE22BE44, 1'b0);

        // Top address, then back-to-back reads of 63 and 0.
        do_write(7'd63, 32'hA5A5A5A5, 4'b1111, 1'b0);
        do_read(7'd63, 32'hA5A5A5A5, 1'b0);
        we_i = 1'b0;
        for (int c = 0; c < Lat + 2; c++) begin
            if (c == 0) begin
                en_i = 1'b1; addr_i = 7'd63;
            end else if (c == 1) begin
                addr_i = 7'd0;
            end else begin
                en_i = 1'b0;
            end
            tick();
            if (c == Lat - 1) begin
                check("b2b_valid0", 32'(q_valid_o), 32'd1);
                check("b2b_data0", q_o, 32'hA5A5A5A5);
            end else if (c == Lat) begin
                check("b2b_valid1", 32'(q_valid_o), 32'd1);
                check("b2b_data1", q_o, 32'h0);
            end else if (c == Lat + 1) begin
                check("b2b_valid_end", 32'(q_valid_o), 32'd0);
            end
        end

        // Out of range: write ignored (100 aliases 36 in the low bits), read gives 0.
        do_write(7'd100, 32'hFFFFFFFF, 4'b1111, 1'b1);
        do_read(7'd36, 32'h0, 1'b0);
        do_read(7'd100, 32'h0, 1'b1);

        // be=0 write: no change, no error.
        do_write(7'd7, 32'h12345678, 4'b0000, 1'b0);
        do_read(7'd7, 32'h0, 1'b0);

        // clr wins over a same-cycle read; writes during init are ignored.
        do_write(7'd10, 32'h5, 4'b1111, 1'b0);
        clr_i = 1'b1; en_i = 1'b1; we_i = 1'b0; addr_i = 7'd10;
        tick();
        clr_i = 1'b0;
        en_i = 1'b1; we_i = 1'b1; data_i = 32'h5; be_i = 4'hF;
        check("clr_ready", 32'(ready_o), 32'd0);
`ifdef SP_RAM_OUT_REG_EN
        tick();
        n_cyc = 1;
        check("clr_drop_valid", 32'(q_valid_o), 32'd0);
        while (!ready_o && n_cyc < 200) begin
            tick();
            n_cyc++;
        end
`else
        check("clr_drop_valid", 32'(q_valid_o), 32'd0);
        wait_ready(n_cyc);
`endif
        en_i = 1'b0; we_i = 1'b0;
        check("clr_init_cycles", 32'(n_cyc), 32'd64);
        do_read(7'd10, 32'h0, 1'b0);

        // Asynchronous reset kills an in-flight q_valid.
        do_write(7'd5, 32'hCAFEF00D, 4'b1111, 1'b0);
        en_i = 1'b1; we_i = 1'b0; addr_i = 7'd5;
        tick();
        en_i = 1'b0;
        repeat (Lat - 1) tick();
        check("pre_rst_valid", 32'(q_valid_o), 32'd1);
        check("pre_rst_data", q_o, 32'hCAFEF00D);
        #2 rst_ni = 1'b0;
        #1;
        check("async_rst_valid", 32'(q_valid_o), 32'd0);
        check("async_rst_q", q_o, 32'h0);
        check("async_rst_ready", 32'(ready_o), 32'd0);
        tick();
        rst_ni = 1'b1;
        wait_ready(n_cyc);
        check("reinit_cycles", 32'(n_cyc), 32'd64);
        do_read(7'd5, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
